// File: rtl/game_pkg.sv
// Shared definitions for the game front end: key codes, keypad map,
// column drive patterns and the debounce state encoding.
package game_pkg;

  localparam logic [3:0] KEY_0 = 4'h0;
  localparam logic [3:0] KEY_1 = 4'h1;
  localparam logic [3:0] KEY_2 = 4'h2;
  localparam logic [3:0] KEY_3 = 4'h3;
  localparam logic [3:0] KEY_4 = 4'h4;
  localparam logic [3:0] KEY_5 = 4'h5;
  localparam logic [3:0] KEY_6 = 4'h6;
  localparam logic [3:0] KEY_7 = 4'h7;
  localparam logic [3:0] KEY_8 = 4'h8;
  localparam logic [3:0] KEY_9 = 4'h9;
  localparam logic [3:0] KEY_A = 4'hA;
  localparam logic [3:0] KEY_B = 4'hB;
  localparam logic [3:0] KEY_C = 4'hC;
  localparam logic [3:0] KEY_D = 4'hD;
  localparam logic [3:0] KEY_E = 4'hE;
  localparam logic [3:0] KEY_F = 4'hF;

  localparam logic [3:0] COL0 = 4'b1110;
  localparam logic [3:0] COL1 = 4'b1101;
  localparam logic [3:0] COL2 = 4'b1011;
  localparam logic [3:0] COL3 = 4'b0111;

  typedef enum logic [1:0] {
    ST_RELEASED,
    ST_PRESS_CHK,
    ST_HELD,
    ST_REL_CHK
  } deb_state_t;

  typedef enum logic [1:0] {
    SCAN_NONE,
    SCAN_SINGLE,
    SCAN_MULTI
  } scan_kind_t;

  function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'h0:    code = KEY_1;
      4'h1:    code = KEY_2;
      4'h2:    code = KEY_3;
      4'h3:    code = KEY_A;
      4'h4:    code = KEY_4;
      4'h5:    code = KEY_5;
      4'h6:    code = KEY_6;
      4'h7:    code = KEY_B;
      4'h8:    code = KEY_7;
      4'h9:    code = KEY_8;
      4'hA:    code = KEY_9;
      4'hB:    code = KEY_C;
      4'hC:    code = KEY_0;
      4'hD:    code = KEY_F;
      4'hE:    code = KEY_E;
      default: code = KEY_D;
    endcase
    return code;
  endfunction

  function automatic logic [3:0] col_drive(input logic [1:0] idx);
    logic [3:0] pat;
    case (idx)
      2'd0:    pat = COL0;
      2'd1:    pat = COL1;
      2'd2:    pat = COL2;
      default: pat = COL3;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/keypad_scanner_sync2.sv
// Two-flop synchronizer with asynchronous active-low reset to a
// configurable idle value.
module sync2 #(
  parameter int WIDTH = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: walks active-low columns, reads synchronized rows,
// classifies each full scan and debounces presses into one-cycle key pulses.
module keypad_scanner
  import game_pkg::*;
#(
  parameter int SCAN_TICKS     = 4,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic       clk_k,
  input  logic       rstn_k,
  input  logic [3:0] row_k,
  output logic [3:0] col_k,
  output logic [3:0] key_k,
  output logic       key_valid_k,
  output logic       key_held_k
);

  localparam int DW    = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);

  logic [3:0]       row_s;
  logic [DW-1:0]    dwell;
  logic [1:0]       col_idx;
  logic             sample;

  logic [2:0]       low_n;
  logic [1:0]       low_row;
  logic [1:0]       acc_hits;
  logic [3:0]       acc_code;
  logic [1:0]       new_hits;
  logic [3:0]       new_code;

  logic             scan_done;
  scan_kind_t       scan_kind;
  logic [3:0]       scan_code;

  deb_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic [3:0]       cand, cand_nxt;
  logic [3:0]       key_nxt;
  logic             held_nxt, valid_nxt;
  logic             is_single;

  sync2 #(
    .WIDTH    (4),
    .RESET_VAL(4'hF)
  ) u_row_sync (
    .clk  (clk_k),
    .rst_n(rstn_k),
    .d    (row_k),
    .q    (row_s)
  );

  assign sample = (dwell == DW'(SCAN_TICKS - 1));
  assign col_k  = col_drive(col_idx);

  always_ff @(posedge clk_k or negedge rstn_k) begin
    if (!rstn_k) begin
      dwell   <= '0;
      col_idx <= 2'd0;
    end else if (sample) begin
      dwell   <= '0;
      col_idx <= col_idx + 2'd1;
    end else begin
      dwell   <= dwell + DW'(1);
    end
  end

  // acc_hits saturates at 2: anything beyond one hit per scan is ghosting.
  always_comb begin
    low_n   = 3'd0;
    low_row = 2'd0;
    for (int r = 0; r < 4; r++) begin
      if (!row_s[r]) begin
        low_n   = low_n + 3'd1;
        low_row = 2'(r);
      end
    end
    new_hits = acc_hits;
    new_code = acc_code;
    if (acc_hits == 2'd2 || low_n > 3'd1 || (low_n == 3'd1 && acc_hits != 2'd0)) begin
      new_hits = 2'd2;
    end else if (low_n == 3'd1) begin
      new_hits = 2'd1;
      new_code = key_map(low_row, col_idx);
    end
  end

  always_ff @(posedge clk_k or negedge rstn_k) begin
    if (!rstn_k) begin
      acc_hits  <= 2'd0;
      acc_code  <= 4'd0;
      scan_done <= 1'b0;
      scan_kind <= SCAN_NONE;
      scan_code <= 4'd0;
    end else if (sample && col_idx == 2'd3) begin
      acc_hits  <= 2'd0;
      acc_code  <= 4'd0;
      scan_done <= 1'b1;
      scan_code <= new_code;
      case (new_hits)
        2'd0:    scan_kind <= SCAN_NONE;
        2'd1:    scan_kind <= SCAN_SINGLE;
        default: scan_kind <= SCAN_MULTI;
      endcase
    end else if (sample) begin
      acc_hits  <= new_hits;
      acc_code  <= new_code;
      scan_done <= 1'b0;
    end else begin
      scan_done <= 1'b0;
    end
  end

  assign is_single = (scan_kind == SCAN_SINGLE);
  assign cnt_inc   = cnt + CNT_W'(1);

  // MULTI falls through the !is_single paths, so it behaves exactly like NONE.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cand_nxt  = cand;
    key_nxt   = key_k;
    held_nxt  = key_held_k;
    valid_nxt = 1'b0;
    if (scan_done) begin
      case (state)
        ST_RELEASED: begin
          if (is_single) begin
            cand_nxt = scan_code;
            if (DEBOUNCE_SCANS <= 1) begin
              key_nxt   = scan_code;
              valid_nxt = 1'b1;
              held_nxt  = 1'b1;
              state_nxt = ST_HELD;
            end else begin
              cnt_nxt   = CNT_W'(1);
              state_nxt = ST_PRESS_CHK;
            end
          end
        end
        ST_PRESS_CHK: begin
          if (!is_single) begin
            state_nxt = ST_RELEASED;
          end else if (scan_code != cand) begin
            cand_nxt = scan_code;
            cnt_nxt  = CNT_W'(1);
          end else if (cnt_inc >= CNT_W'(DEBOUNCE_SCANS)) begin
            key_nxt   = cand;
            valid_nxt = 1'b1;
            held_nxt  = 1'b1;
            state_nxt = ST_HELD;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
        ST_HELD: begin
          if (!is_single) begin
            if (DEBOUNCE_SCANS <= 1) begin
              held_nxt  = 1'b0;
              state_nxt = ST_RELEASED;
            end else begin
              cnt_nxt   = CNT_W'(1);
              state_nxt = ST_REL_CHK;
            end
          end
        end
        default: begin
          if (is_single) begin
            state_nxt = ST_HELD;
          end else if (cnt_inc >= CNT_W'(DEBOUNCE_SCANS)) begin
            held_nxt  = 1'b0;
            state_nxt = ST_RELEASED;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_k or negedge rstn_k) begin
    if (!rstn_k) begin
      state       <= ST_RELEASED;
      cnt         <= '0;
      cand        <= 4'd0;
      key_k       <= 4'd0;
      key_held_k  <= 1'b0;
      key_valid_k <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      cand        <= cand_nxt;
      key_k       <= key_nxt;
      key_held_k  <= held_nxt;
      key_valid_k <= valid_nxt;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a switch-matrix model pulls rows low
// for pressed keys whose column is driven; each task checks one scenario.
module tb_keypad_scanner;

  logic       clk_k;
  logic       rstn_k;
  logic [3:0] row_k;
  logic [3:0] col_k;
  logic [3:0] key_k;
  logic       key_valid_k;
  logic       key_held_k;

  logic [15:0] press;
  int tests_run;
  int failed;
  int cyc;
  int pulse_cnt;
  int last_pulse;

  keypad_scanner #(
    .SCAN_TICKS    (4),
    .DEBOUNCE_SCANS(3)
  ) dut (
    .clk_k      (clk_k),
    .rstn_k     (rstn_k),
    .row_k      (row_k),
    .col_k      (col_k),
    .key_k      (key_k),
    .key_valid_k(key_valid_k),
    .key_held_k (key_held_k)
  );

  initial clk_k = 1'b0;
  always #5 clk_k = ~clk_k;

  // press index is row*4 + col
  always_comb begin
    row_k = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (press[r*4+c] && !col_k[c]) row_k[r] = 1'b0;
  end

  always @(posedge clk_k) cyc <= cyc + 1;

  always @(negedge clk_k) begin
    if (key_valid_k) begin
      pulse_cnt  <= pulse_cnt + 1;
      last_pulse <= cyc;
    end
  end

  task automatic wait_col(input logic [3:0] pat, output int s);
    int n;
    n = 0;
    @(negedge clk_k);
    while (col_k !== pat && n < 64) begin
      @(negedge clk_k);
      n++;
    end
    if (col_k !== pat) begin
      tests_run++;
      failed++;
      $display("[TB] FAIL wait_col: col_k=%b never reached %b", col_k, pat);
    end
    s = cyc;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk_k);
  endtask

  task automatic start_press(input int idx, output int s);
    int d;
    wait_col(4'b0111, d);
    press[idx] = 1'b1;
    wait_col(4'b1110, s);
  endtask

  task automatic test_reset;
    rstn_k = 1'b0;
    press  = '0;
    repeat (3) @(negedge clk_k);
    #1;
    tests_run++;
    if (col_k !== 4'b1110) begin failed++; $display("[TB] FAIL reset_col: got %b want 1110", col_k); end
    tests_run++;
    if (key_k !== 4'h0) begin failed++; $display("[TB] FAIL reset_key: got %h want 0", key_k); end
    tests_run++;
    if (key_valid_k !== 1'b0) begin failed++; $display("[TB] FAIL reset_valid: got %b want 0", key_valid_k); end
    tests_run++;
    if (key_held_k !== 1'b0) begin failed++; $display("[TB] FAIL reset_held: got %b want 0", key_held_k); end
    @(negedge clk_k);
    rstn_k = 1'b1;
    repeat (3) @(negedge clk_k);
    tests_run++;
    if (col_k !== 4'b1110) begin failed++; $display("[TB] FAIL first_dwell: got %b want 1110", col_k); end
    @(negedge clk_k);
    tests_run++;
    if (col_k !== 4'b1101) begin failed++; $display("[TB] FAIL first_step: got %b want 1101", col_k); end
  endtask

  task automatic test_idle;
    int p0, s1, s2, d;
    p0 = pulse_cnt;
    wait_col(4'b0111, d);
    wait_col(4'b1110, s1);
    wait_col(4'b0111, d);
    wait_col(4'b1110, s2);
    tests_run++;
    if (s2 - s1 != 16) begin failed++; $display("[TB] FAIL scan_period: got %0d want 16", s2 - s1); end
    wait_until(cyc + 200);
    tests_run++;
    if (pulse_cnt != p0) begin failed++; $display("[TB] FAIL idle_pulses: got %0d want %0d", pulse_cnt, p0); end
    tests_run++;
    if (key_held_k !== 1'b0) begin failed++; $display("[TB] FAIL idle_held: got %b want 0", key_held_k); end
  endtask

  task automatic test_hold_key5;
    int p0, s;
    p0 = pulse_cnt;
    start_press(5, s);
    wait_until(s + 157);
    press[5] = 1'b0;
    tests_run++;
    if (pulse_cnt != p0 + 1) begin failed++; $display("[TB] FAIL key5_pulses: got %0d want %0d", pulse_cnt - p0, 1); end
    tests_run++;
    if (last_pulse != s + 49) begin failed++; $display("[TB] FAIL key5_latency: got %0d want 49", last_pulse - s); end
    tests_run++;
    if (key_k !== 4'h5) begin failed++; $display("[TB] FAIL key5_code: got %h want 5", key_k); end
    wait_until(s + 190);
    tests_run++;
    if (key_held_k !== 1'b1) begin failed++; $display("[TB] FAIL key5_held_after_release: got %b want 1", key_held_k); end
    wait_until(s + 215);
    tests_run++;
    if (key_held_k !== 1'b0) begin failed++; $display("[TB] FAIL key5_release: got %b want 0", key_held_k); end
  endtask

  task automatic test_bounce_key9;
    int p0, s;
    p0 = pulse_cnt;
    start_press(10, s);
    wait_until(s + 29);
    press[10] = 1'b0;
    wait_until(s + 45);
    press[10] = 1'b1;
    wait_until(s + 110);
    tests_run++;
    if (pulse_cnt != p0 + 1) begin failed++; $display("[TB] FAIL key9_pulses: got %0d want 1", pulse_cnt - p0); end
    tests_run++;
    if (last_pulse != s + 97) begin failed++; $display("[TB] FAIL key9_timing: got %0d want 97", last_pulse - s); end
    tests_run++;
    if (key_k !== 4'h9) begin failed++; $display("[TB] FAIL key9_code: got %h want 9", key_k); end
    press[10] = 1'b0;
    wait_until(cyc + 80);
  endtask

  task automatic test_multi;
    int p0, s;
    p0 = pulse_cnt;
    press[1] = 1'b1;
    start_press(0, s);
    wait_until(s + 80);
    tests_run++;
    if (pulse_cnt != p0) begin failed++; $display("[TB] FAIL multi_pulses: got %0d want 0", pulse_cnt - p0); end
    tests_run++;
    if (key_held_k !== 1'b0) begin failed++; $display("[TB] FAIL multi_held: got %b want 0", key_held_k); end
    tests_run++;
    if (key_k !== 4'h9) begin failed++; $display("[TB] FAIL multi_key: got %h want 9", key_k); end
    press = '0;
    wait_until(cyc + 20);
  endtask

  task automatic test_rollover;
    int p0, s;
    p0 = pulse_cnt;
    start_press(3, s);
    wait_until(s + 77);
    press[15] = 1'b1;
    wait_until(s + 93);
    press[3] = 1'b0;
    wait_until(s + 160);
    tests_run++;
    if (pulse_cnt != p0 + 1) begin failed++; $display("[TB] FAIL rollover_pulses: got %0d want 1", pulse_cnt - p0); end
    tests_run++;
    if (key_k !== 4'hA) begin failed++; $display("[TB] FAIL rollover_key: got %h want a", key_k); end
    tests_run++;
    if (key_held_k !== 1'b1) begin failed++; $display("[TB] FAIL rollover_held: got %b want 1", key_held_k); end
    press[15] = 1'b0;
    wait_until(cyc + 70);
    tests_run++;
    if (key_held_k !== 1'b0) begin failed++; $display("[TB] FAIL rollover_release: got %b want 0", key_held_k); end
    tests_run++;
    if (pulse_cnt != p0 + 1) begin failed++; $display("[TB] FAIL rollover_no_d: got %0d want 1", pulse_cnt - p0); end
  endtask

  task automatic test_reset_midpress;
    int p0, s, r;
    p0 = pulse_cnt;
    start_press(12, s);
    wait_until(s + 20);
    rstn_k = 1'b0;
    #1;
    tests_run++;
    if (key_k !== 4'h0) begin failed++; $display("[TB] FAIL midreset_key: got %h want 0", key_k); end
    tests_run++;
    if (col_k !== 4'b1110) begin failed++; $display("[TB] FAIL midreset_col: got %b want 1110", col_k); end
    repeat (3) @(negedge clk_k);
    rstn_k = 1'b1;
    r = cyc;
    wait_until(r + 60);
    tests_run++;
    if (pulse_cnt != p0 + 1) begin failed++; $display("[TB] FAIL key0_pulses: got %0d want 1", pulse_cnt - p0); end
    tests_run++;
    if (last_pulse != r + 49) begin failed++; $display("[TB] FAIL key0_latency: got %0d want 49", last_pulse - r); end
    tests_run++;
    if (key_k !== 4'h0 || key_held_k !== 1'b1) begin
      failed++;
      $display("[TB] FAIL key0_state: got key=%h held=%b want key=0 held=1", key_k, key_held_k);
    end
  endtask

  initial begin
    tests_run  = 0;
    failed     = 0;
    cyc        = 0;
    pulse_cnt  = 0;
    last_pulse = 0;
    press      = '0;
    rstn_k     = 1'b0;
    test_reset();
    test_idle();
    test_hold_key5();
    test_bounce_key9();
    test_multi();
    test_rollover();
    test_reset_midpress();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
